// File: rtl/mem_wb_stage_pkg.sv
// Shared encodings for the writeback stage: load sizes, the ebreak opcode and
// the one-bit RUN/HALT state encoding.
package mem_wb_stage_pkg;

  typedef logic [1:0] load_size_t;

  localparam load_size_t LOAD_SIZE_B = 2'b00;
  localparam load_size_t LOAD_SIZE_H = 2'b01;
  localparam load_size_t LOAD_SIZE_W = 2'b10;
  localparam load_size_t LOAD_SIZE_D = 2'b11;

  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  localparam logic [0:0] WB_STATE_RUN  = 1'b0;
  localparam logic [0:0] WB_STATE_HALT = 1'b1;

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM -> WB handshake/payload plus the register-file write and difftest
// outputs. The slave modport is the stage; the master modport is upstream.
interface mem_wb_stage_if #(
  parameter int REG_W = 64,
  parameter int IDX_W = 5
);
  logic             mem_wb_valid_i;
  logic             mem_wb_ready_o;
  logic             mem_wb_rd_en_i;
  logic [IDX_W-1:0] mem_wb_rd_index_i;
  logic [REG_W-1:0] mem_wb_alu_data_i;
  logic             mem_wb_load_i;
  logic [1:0]       mem_wb_load_size_i;
  logic             mem_wb_load_unsigned_i;
  logic [2:0]       mem_wb_addr_low_i;
  logic [REG_W-1:0] mem_wb_rdata_i;
  logic [REG_W-1:0] mem_wb_pc_i;
  logic [31:0]      mem_wb_inst_i;

  logic             wb_inst_valid_o;
  logic             wb_rd_en_o;
  logic [IDX_W-1:0] wb_rd_index_o;
  logic [REG_W-1:0] wb_rd_data_o;
  logic [REG_W-1:0] wb_pc_o;
  logic [31:0]      wb_inst_o;
  logic [63:0]      wb_instret_o;
  logic             wb_halt_o;

  modport slave (
    input  mem_wb_valid_i, mem_wb_rd_en_i, mem_wb_rd_index_i, mem_wb_alu_data_i,
           mem_wb_load_i, mem_wb_load_size_i, mem_wb_load_unsigned_i,
           mem_wb_addr_low_i, mem_wb_rdata_i, mem_wb_pc_i, mem_wb_inst_i,
    output mem_wb_ready_o, wb_inst_valid_o, wb_rd_en_o, wb_rd_index_o,
           wb_rd_data_o, wb_pc_o, wb_inst_o, wb_instret_o, wb_halt_o
  );

  modport master (
    output mem_wb_valid_i, mem_wb_rd_en_i, mem_wb_rd_index_i, mem_wb_alu_data_i,
           mem_wb_load_i, mem_wb_load_size_i, mem_wb_load_unsigned_i,
           mem_wb_addr_low_i, mem_wb_rdata_i, mem_wb_pc_i, mem_wb_inst_i,
    input  mem_wb_ready_o, wb_inst_valid_o, wb_rd_en_o, wb_rd_index_o,
           wb_rd_data_o, wb_pc_o, wb_inst_o, wb_instret_o, wb_halt_o
  );

endinterface

// File: rtl/mem_wb_stage_load_ext.sv
// Combinational load aligner: shifts the doubleword down by the byte offset,
// keeps 1/2/4/8 bytes and sign- or zero-extends to REG_W.
module wb_load_ext
  import mem_wb_stage_pkg::*;
#(
  parameter int REG_W = 64
) (
  input  logic [REG_W-1:0] i_rdata,
  input  logic [2:0]       i_addr_low,
  input  load_size_t       i_size,
  input  logic             i_unsigned,
  output logic [REG_W-1:0] o_data
);

  logic [REG_W-1:0] w_sh;

  // Misaligned offsets simply pull zeros in from the top.
  assign w_sh = i_rdata >> {i_addr_low, 3'b000};

  always_comb begin
    o_data = w_sh;
    case (i_size)
      LOAD_SIZE_B: o_data = {{(REG_W-8){~i_unsigned & w_sh[7]}}, w_sh[7:0]};
      LOAD_SIZE_H: o_data = {{(REG_W-16){~i_unsigned & w_sh[15]}}, w_sh[15:0]};
      LOAD_SIZE_W: o_data = {{(REG_W-32){~i_unsigned & w_sh[31]}}, w_sh[31:0]};
      default:     o_data = w_sh;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Writeback stage: accepts retiring instructions from MEM, registers the
// regfile write for one cycle, counts commits and halts on ebreak.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int REG_W = 64,
  parameter int IDX_W = 5
) (
  input  logic          clk,
  input  logic          rst,
  mem_wb_stage_if.slave bus
);

  logic [0:0]       r_state;
  logic             r_inst_valid;
  logic             r_rd_en;
  logic [IDX_W-1:0] r_rd_index;
  logic [REG_W-1:0] r_rd_data;
  logic [REG_W-1:0] r_pc;
  logic [31:0]      r_inst;
  logic [63:0]      r_instret;

  logic             w_ready;
  logic             w_fire;
  logic             w_is_ebreak;
  logic             w_rd_en;
  logic [REG_W-1:0] w_ext_data;
  logic [REG_W-1:0] w_result;

  wb_load_ext #(.REG_W(REG_W)) u_load_ext (
    .i_rdata    (bus.mem_wb_rdata_i),
    .i_addr_low (bus.mem_wb_addr_low_i),
    .i_size     (bus.mem_wb_load_size_i),
    .i_unsigned (bus.mem_wb_load_unsigned_i),
    .o_data     (w_ext_data)
  );

  assign w_ready     = (r_state == WB_STATE_RUN);
  assign w_fire      = bus.mem_wb_valid_i & w_ready;
  assign w_is_ebreak = (bus.mem_wb_inst_i == INST_EBREAK);
  assign w_result    = bus.mem_wb_load_i ? w_ext_data : bus.mem_wb_alu_data_i;
  // x0 is never written, and ebreak never writes regardless of its rd field.
  assign w_rd_en     = bus.mem_wb_rd_en_i & (|bus.mem_wb_rd_index_i) & ~w_is_ebreak;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= WB_STATE_RUN;
      r_inst_valid <= 1'b0;
      r_rd_en      <= 1'b0;
      r_rd_index   <= '0;
      r_rd_data    <= '0;
      r_pc         <= '0;
      r_inst       <= '0;
      r_instret    <= '0;
    end else begin
      r_inst_valid <= w_fire;
      r_rd_en      <= w_fire & w_rd_en;
      if (w_fire) begin
        r_rd_index <= bus.mem_wb_rd_index_i;
        r_rd_data  <= w_result;
        r_pc       <= bus.mem_wb_pc_i;
        r_inst     <= bus.mem_wb_inst_i;
      end
      // Counting commits (not accepts) means a reset mid-flight drops the count too.
      if (r_inst_valid) begin
        r_instret <= r_instret + 64'd1;
      end
      if (w_fire && w_is_ebreak) begin
        r_state <= WB_STATE_HALT;
      end
    end
  end

  assign bus.mem_wb_ready_o  = w_ready;
  assign bus.wb_inst_valid_o = r_inst_valid;
  assign bus.wb_rd_en_o      = r_rd_en;
  assign bus.wb_rd_index_o   = r_rd_index;
  assign bus.wb_rd_data_o    = r_rd_data;
  assign bus.wb_pc_o         = r_pc;
  assign bus.wb_inst_o       = r_inst;
  assign bus.wb_instret_o    = r_instret;
  assign bus.wb_halt_o       = (r_state == WB_STATE_HALT);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed and randomized transfers
// compared against a byte-level behavioural model of writeback.
module tb_mem_wb_stage;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  mem_wb_stage_if #(.REG_W(64), .IDX_W(5)) bus ();

  mem_wb_stage #(.REG_W(64), .IDX_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: pick bytes one at a time, then fill the upper bytes.
  function automatic logic [63:0] model_load(input logic [63:0] rdata, input int off,
                                             input int size, input logic uns);
    logic [63:0] v;
    int nb;
    v  = '0;
    nb = 1 << size;
    for (int b = 0; b < nb; b++)
      if (off + b < 8) v[b*8 +: 8] = rdata[(off+b)*8 +: 8];
    if (!uns && size != 3 && v[nb*8-1])
      for (int b = nb; b < 8; b++) v[b*8 +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [63:0] model_result(input logic load, input logic [63:0] alu,
                                               input logic [63:0] rdata, input int off,
                                               input int size, input logic uns);
    return load ? model_load(rdata, off, size, uns) : alu;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic rd_en, input logic [4:0] idx,
                       input logic [63:0] alu, input logic load, input logic [1:0] size,
                       input logic uns, input logic [2:0] off, input logic [63:0] rdata,
                       input logic [63:0] pc, input logic [31:0] inst);
    bus.mem_wb_valid_i         = valid;
    bus.mem_wb_rd_en_i         = rd_en;
    bus.mem_wb_rd_index_i      = idx;
    bus.mem_wb_alu_data_i      = alu;
    bus.mem_wb_load_i          = load;
    bus.mem_wb_load_size_i     = size;
    bus.mem_wb_load_unsigned_i = uns;
    bus.mem_wb_addr_low_i      = off;
    bus.mem_wb_rdata_i         = rdata;
    bus.mem_wb_pc_i            = pc;
    bus.mem_wb_inst_i          = inst;
    if (valid)
      $display("txn: rd_en=%0b idx=%0d load=%0b size=%0d uns=%0b off=%0d alu=%h rdata=%h pc=%h inst=%h",
               rd_en, idx, load, size, uns, off, alu, rdata, pc, inst);
  endtask

  task automatic apply_reset();
    bus.mem_wb_valid_i = 1'b0;
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    drive(1'b0, 1'b0, 5'd0, '0, 1'b0, 2'd0, 1'b0, 3'd0, '0, '0, 32'h0);
    rst = 1'b0;
    #3;
    checks++;
    if (bus.mem_wb_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b want 1", bus.mem_wb_ready_o);
    end
    repeat (2) step();
    checks++;
    if ({bus.wb_inst_valid_o, bus.wb_rd_en_o, bus.wb_rd_index_o, bus.wb_rd_data_o, bus.wb_pc_o,
         bus.wb_inst_o, bus.wb_instret_o, bus.wb_halt_o} !== '0) begin
      errors++; $display("FAIL reset_outputs: valid=%b rd_en=%b idx=%0d data=%h instret=%0d halt=%b want all 0",
                         bus.wb_inst_valid_o, bus.wb_rd_en_o, bus.wb_rd_index_o, bus.wb_rd_data_o,
                         bus.wb_instret_o, bus.wb_halt_o);
    end
    rst = 1'b1;
  endtask

  task automatic test_alu();
    apply_reset();
    drive(1'b1, 1'b1, 5'd5, 64'h1234, 1'b0, 2'd3, 1'b0, 3'd0, 64'hDEAD, 64'h8000_0000, 32'h0000_0013);
    step();
    bus.mem_wb_valid_i = 1'b0;
    checks++;
    if ({bus.wb_inst_valid_o, bus.wb_rd_en_o, bus.wb_rd_index_o, bus.wb_rd_data_o} !== {1'b1, 1'b1, 5'd5, 64'h1234}) begin
      errors++; $display("FAIL alu_commit: valid=%b rd_en=%b idx=%0d data=%h want 1 1 5 1234",
                         bus.wb_inst_valid_o, bus.wb_rd_en_o, bus.wb_rd_index_o, bus.wb_rd_data_o);
    end
    checks++;
    if ({bus.wb_pc_o, bus.wb_inst_o} !== {64'h8000_0000, 32'h0000_0013}) begin
      errors++; $display("FAIL alu_pc_inst: pc=%h inst=%h want 80000000 00000013", bus.wb_pc_o, bus.wb_inst_o);
    end
    step();
    checks++;
    if ({bus.wb_inst_valid_o, bus.wb_rd_en_o, bus.wb_instret_o} !== {1'b0, 1'b0, 64'd1}) begin
      errors++; $display("FAIL alu_after: valid=%b rd_en=%b instret=%0d want 0 0 1",
                         bus.wb_inst_valid_o, bus.wb_rd_en_o, bus.wb_instret_o);
    end
    checks++;
    if ({bus.wb_rd_index_o, bus.wb_rd_data_o} !== {5'd5, 64'h1234}) begin
      errors++; $display("FAIL alu_hold: idx=%0d data=%h want 5 1234", bus.wb_rd_index_o, bus.wb_rd_data_o);
    end
  endtask

  task automatic test_load();
    logic [63:0] rd_tab [3];
    int          sz_tab [3];
    logic        un_tab [3];
    int          of_tab [3];
    logic [63:0] ex_tab [3];
    sz_tab = '{0, 0, 2};
    un_tab = '{1'b0, 1'b1, 1'b0};
    of_tab = '{0, 0, 4};
    ex_tab = '{64'hFFFF_FFFF_FFFF_FF80, 64'h80, 64'hFFFF_FFFF_8000_0000};
    for (int i = 0; i < 3; i++) rd_tab[i] = 64'h8000_0000_0000_0080;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 5'd9, 64'h5555, 1'b1, 2'(sz_tab[i]), un_tab[i], 3'(of_tab[i]),
            rd_tab[i], 64'h100 + 64'(i), 32'h0000_3003);
      step();
      bus.mem_wb_valid_i = 1'b0;
      checks++;
      if (bus.wb_rd_data_o !== ex_tab[i]) begin
        errors++; $display("FAIL load_dir%0d: got %h want %h", i, bus.wb_rd_data_o, ex_tab[i]);
      end
    end
    for (int i = 0; i < 30; i++) begin
      logic [63:0] rdata;
      int sz, off;
      logic uns;
      rdata = {$urandom, $urandom};
      sz    = int'($urandom_range(0, 3));
      off   = int'($urandom_range(0, 7));
      uns   = 1'($urandom);
      drive(1'b1, 1'b1, 5'd1, '0, 1'b1, 2'(sz), uns, 3'(off), rdata, '0, 32'h0000_3003);
      step();
      bus.mem_wb_valid_i = 1'b0;
      checks++;
      if (bus.wb_rd_data_o !== model_load(rdata, off, sz, uns)) begin
        errors++; $display("FAIL load_rand%0d: got %h want %h (size=%0d off=%0d uns=%0b)",
                           i, bus.wb_rd_data_o, model_load(rdata, off, sz, uns), sz, off, uns);
      end
    end
    step();
  endtask

  task automatic test_rd0();
    drive(1'b1, 1'b1, 5'd0, 64'hABCD, 1'b0, 2'd0, 1'b0, 3'd0, '0, 64'h44, 32'h0000_0013);
    step();
    bus.mem_wb_valid_i = 1'b0;
    checks++;
    if ({bus.wb_inst_valid_o, bus.wb_rd_en_o} !== 2'b10) begin
      errors++; $display("FAIL rd0: valid=%b rd_en=%b want 1 0", bus.wb_inst_valid_o, bus.wb_rd_en_o);
    end
    step();
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 5'(i + 1), 64'(i * 3 + 7), 1'b0, 2'd3, 1'b0, 3'd0, '0, 64'(i * 4), 32'h0000_0013);
      step();
      checks++;
      if ({bus.wb_inst_valid_o, bus.wb_rd_index_o, bus.wb_rd_data_o} !== {1'b1, 5'(i + 1), 64'(i * 3 + 7)}) begin
        errors++; $display("FAIL b2b_%0d: valid=%b idx=%0d data=%h want 1 %0d %h", i, bus.wb_inst_valid_o,
                           bus.wb_rd_index_o, bus.wb_rd_data_o, i + 1, 64'(i * 3 + 7));
      end
    end
    bus.mem_wb_valid_i = 1'b0;
    step();
    checks++;
    if ({bus.wb_inst_valid_o, bus.wb_instret_o} !== {1'b0, 64'd10}) begin
      errors++; $display("FAIL b2b_instret: valid=%b instret=%0d want 0 10", bus.wb_inst_valid_o, bus.wb_instret_o);
    end
  endtask

  task automatic test_random();
    logic        fired;
    logic        exp_rd_en;
    logic [4:0]  exp_idx;
    logic [63:0] exp_data, exp_pc;
    logic [31:0] exp_inst;
    longint      accepted;
    apply_reset();
    accepted = 0;
    for (int i = 0; i < 40; i++) begin
      logic v, rde, ld, un;
      logic [4:0] idx;
      logic [63:0] alu, rdata, pc;
      logic [31:0] inst;
      int sz, off;
      v = 1'($urandom); rde = 1'($urandom); ld = 1'($urandom); un = 1'($urandom);
      idx = 5'($urandom); alu = {$urandom, $urandom}; rdata = {$urandom, $urandom};
      pc = {$urandom, $urandom}; inst = $urandom;
      if (inst == EBREAK) inst = inst ^ 32'h1;
      sz = int'($urandom_range(0, 3)); off = int'($urandom_range(0, 7));
      drive(v, rde, idx, alu, ld, 2'(sz), un, 3'(off), rdata, pc, inst);
      fired     = v;
      exp_rd_en = v && rde && (idx != 0);
      exp_idx   = idx;
      exp_data  = model_result(ld, alu, rdata, off, sz, un);
      exp_pc    = pc;
      exp_inst  = inst;
      step();
      checks++;
      if ({bus.wb_inst_valid_o, bus.wb_rd_en_o} !== {fired, exp_rd_en}) begin
        errors++; $display("FAIL rand_ctl%0d: valid=%b rd_en=%b want %b %b", i, bus.wb_inst_valid_o,
                           bus.wb_rd_en_o, fired, exp_rd_en);
      end
      if (fired) begin
        checks++;
        if ({bus.wb_rd_index_o, bus.wb_rd_data_o, bus.wb_pc_o, bus.wb_inst_o} !== {exp_idx, exp_data, exp_pc, exp_inst}) begin
          errors++; $display("FAIL rand_data%0d: idx=%0d data=%h pc=%h inst=%h want %0d %h %h %h", i,
                             bus.wb_rd_index_o, bus.wb_rd_data_o, bus.wb_pc_o, bus.wb_inst_o,
                             exp_idx, exp_data, exp_pc, exp_inst);
        end
      end
      // Commits from earlier accepts are already counted by this edge.
      checks++;
      if (bus.wb_instret_o !== 64'(accepted)) begin
        errors++; $display("FAIL rand_instret%0d: got %0d want %0d", i, bus.wb_instret_o, accepted);
      end
      if (fired) accepted++;
    end
    bus.mem_wb_valid_i = 1'b0;
    step();
  endtask

  task automatic test_ebreak();
    apply_reset();
    drive(1'b1, 1'b1, 5'd3, 64'h77, 1'b0, 2'd3, 1'b0, 3'd0, '0, 64'h200, EBREAK);
    step();
    drive(1'b1, 1'b1, 5'd4, 64'h99, 1'b0, 2'd3, 1'b0, 3'd0, '0, 64'h204, 32'h0000_0013);
    checks++;
    if ({bus.wb_inst_valid_o, bus.wb_rd_en_o, bus.wb_halt_o, bus.mem_wb_ready_o} !== 4'b1010) begin
      errors++; $display("FAIL ebreak_commit: valid=%b rd_en=%b halt=%b ready=%b want 1 0 1 0",
                         bus.wb_inst_valid_o, bus.wb_rd_en_o, bus.wb_halt_o, bus.mem_wb_ready_o);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if ({bus.wb_inst_valid_o, bus.wb_halt_o, bus.mem_wb_ready_o, bus.wb_instret_o} !== {3'b010, 64'd1}) begin
        errors++; $display("FAIL ebreak_held%0d: valid=%b halt=%b ready=%b instret=%0d want 0 1 0 1", i,
                           bus.wb_inst_valid_o, bus.wb_halt_o, bus.mem_wb_ready_o, bus.wb_instret_o);
      end
    end
    bus.mem_wb_valid_i = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.wb_halt_o, bus.mem_wb_ready_o, bus.wb_instret_o} !== {2'b01, 64'd0}) begin
      errors++; $display("FAIL ebreak_reset: halt=%b ready=%b instret=%0d want 0 1 0",
                         bus.wb_halt_o, bus.mem_wb_ready_o, bus.wb_instret_o);
    end
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    drive(1'b1, 1'b1, 5'd7, 64'hCAFE, 1'b0, 2'd3, 1'b0, 3'd0, '0, 64'h300, 32'h0000_0013);
    step();
    bus.mem_wb_valid_i = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.wb_inst_valid_o, bus.wb_rd_en_o, bus.wb_rd_index_o, bus.wb_rd_data_o, bus.wb_pc_o,
         bus.wb_inst_o, bus.wb_instret_o} !== '0) begin
      errors++; $display("FAIL mid_reset_outputs: valid=%b rd_en=%b idx=%0d data=%h instret=%0d want all 0",
                         bus.wb_inst_valid_o, bus.wb_rd_en_o, bus.wb_rd_index_o, bus.wb_rd_data_o, bus.wb_instret_o);
    end
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({bus.wb_inst_valid_o, bus.wb_rd_en_o, bus.wb_instret_o} !== '0) begin
      errors++; $display("FAIL mid_reset_instret: valid=%b rd_en=%b instret=%0d want 0 0 0",
                         bus.wb_inst_valid_o, bus.wb_rd_en_o, bus.wb_instret_o);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    test_reset();
    test_alu();
    test_load();
    test_rd0();
    test_back_to_back();
    test_random();
    test_ebreak();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Writeback pipeline stage sitting directly upstream of the ID-stage register file. It accepts one retiring instruction per cycle from MEM over a valid/ready handshake, aligns and sign- or zero-extends load data, and registers the result. It then drives the register file write port (valid, enable, index, data) for exactly one cycle. It also keeps a retired-instruction counter and halts the core on `ebreak`.

## Interface
Parameters:
- REG_W, 64, register/data width (`REG_BUS`)
- IDX_W, 5, register index width (`REG_INDEX_BUS`)

Ports:
- clk  in  1  core clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- mem_wb_valid_i  in  1  MEM holds a retiring instruction
- mem_wb_ready_o  out  1  stage accepts this cycle
- mem_wb_rd_en_i  in  1  instruction writes rd
- mem_wb_rd_index_i  in  IDX_W  rd index
- mem_wb_alu_data_i  in  REG_W  non-load result
- mem_wb_load_i  in  1  result comes from memory
- mem_wb_load_size_i  in  2  00 byte, 01 half, 10 word, 11 dword
- mem_wb_load_unsigned_i  in  1  zero-extend when 1
- mem_wb_addr_low_i  in  3  byte offset within doubleword
- mem_wb_rdata_i  in  REG_W  doubleword-aligned memory read data
- mem_wb_pc_i  in  REG_W  instruction PC
- mem_wb_inst_i  in  32  instruction word
- wb_inst_valid_o  out  1  to regfile `inst_valid`
- wb_rd_en_o  out  1  to regfile `rd_en`
- wb_rd_index_o  out  IDX_W  to regfile `rd_index`
- wb_rd_data_o  out  REG_W  to regfile `rd_data`
- wb_pc_o  out  REG_W  committed PC (difftest)
- wb_inst_o  out  32  committed instruction (difftest)
- wb_instret_o  out  64  retired-instruction count
- wb_halt_o  out  1  core halted by `ebreak`

## Operation
- Handshake: transfer occurs when `mem_wb_valid_i & mem_wb_ready_o` at a rising edge. `mem_wb_ready_o = (state == RUN)`, combinational from state only. Upstream holds its payload while not ready.
- State machine has two states: RUN (reset state) and HALT.
  - RUN -> HALT on a transfer whose `mem_wb_inst_i == 32'h0010_0073`.
  - HALT is left only by reset.
- Result select: `mem_wb_load_i ? ext : mem_wb_alu_data_i`.
- Load extension:
  - Shift: `sh = mem_wb_rdata_i >> (addr_low*8)`.
  - Take the low 8/16/32/64 bits per size.
  - Sign-extend from the top taken bit unless unsigned. Size 11 ignores unsigned.
- Misaligned offsets are not checked. The shifted value is zero-filled from the top and then extended as above.
- Captured `rd_en` is forced 0 when rd_index == 0, and also for the `ebreak` instruction.
- Output register update:
  - On a transfer: pc, inst, rd index, data and masked rd_en are loaded, and `wb_inst_valid_o` is set to 1.
  - Otherwise `wb_inst_valid_o` = 0 and `wb_rd_en_o` = 0. Index, data, pc and inst hold their last values.
- `wb_instret_o` increments by 1 on every edge where `wb_inst_valid_o` is 1. It counts commits, not accepts, and wraps modulo 2^64.
- `wb_halt_o = (state == HALT)`.

## Timing
- Reset (rst low, asynchronous): every output register is 0, state is RUN, instret is 0. `mem_wb_ready_o` is therefore 1 during reset.
- Latency is one cycle: payload accepted at edge N is presented on the wb_* outputs during cycle N+1. The regfile write occurs at edge N+1.
- Throughput is one instruction per cycle. Back-to-back transfers keep `wb_inst_valid_o` high continuously.
- `wb_instret_o` reflects commit k at edge N+1, i.e. it is visible in cycle N+2.
- `ebreak` accepted at edge N:
  - In cycle N+1: `wb_inst_valid_o` = 1, `wb_rd_en_o` = 0, `wb_halt_o` = 1, `mem_wb_ready_o` = 0.
  - No further transfers occur.
- Reset asserted mid-stream: any in-flight instruction is discarded with no write, and instret is not incremented for it.

## Structure
- Add to `defines.v`: `LOAD_SIZE_B/H/W/D` codes, `INST_EBREAK` = 32'h0010_0073, and `WB_STATE_RUN/HALT` encoding (1 bit).
- One combinational sub-module, `wb_load_ext` (inputs rdata, addr_low, size, unsigned; output REG_W data), instantiated once.
- Everything else (handshake, output registers, FSM, counter) lives in `mem_wb_stage`.

## Test plan
- Reset, then one ALU op with rd=5 and data 64'h1234: cycle after accept shows valid=1, rd_en=1, index=5, data=64'h1234; next cycle valid=0; instret=1.
- Load with rdata 64'h8000_0000_0000_0080:
  - byte, offset 0, signed -> 64'hFFFF_FFFF_FFFF_FF80
  - same, unsigned -> 64'h80
  - word, offset 4, signed -> 64'hFFFF_FFFF_8000_0000
- rd=0 with rd_en=1: wb_inst_valid_o=1, wb_rd_en_o=0.
- 10 back-to-back transfers: wb_inst_valid_o high for 10 consecutive cycles; instret=10.
- `ebreak` followed by a held ALU op: halt=1, ready=0 from the next cycle, the held op is never committed, instret=1 (ebreak only). Asserting rst clears halt and instret, and ready returns to 1.
- Drop rst low in the cycle after accept: outputs go to 0 immediately, no regfile write, instret=0.
